// File: rtl/result_bank.sv
// Circular history of the last DEPTH results with store, clear, M+ accumulate
// and recall navigation; drives the display value and a history-browse value.
module result_bank #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           A,
   input  logic [2:0]                 Sel,
   output logic [WIDTH-1:0]           Out,
   output logic [WIDTH-1:0]           Recall,
   output logic [$clog2(DEPTH+1)-1:0] Count,
   output logic                       Full,
   output logic                       Dropped,
   output logic                       Carry
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   localparam logic [2:0] OP_STORE = 3'b011;
   localparam logic [2:0] OP_CLEAR = 3'b100;
   localparam logic [2:0] OP_ACCUM = 3'b101;
   localparam logic [2:0] OP_BACK  = 3'b110;
   localparam logic [2:0] OP_FWD   = 3'b111;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_off;
   logic [CW-1:0]    cnt;
   logic [PW-1:0]    last;
   logic [PW-1:0]    rd_idx;
   logic [WIDTH:0]   sum;
   logic             empty;
   logic             full;
   logic             we;
   logic [PW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;

   assign empty  = (cnt == '0);
   assign full   = (cnt == CW'(DEPTH));
   assign last   = wr_ptr - PW'(1);
   assign rd_idx = last - rd_off;
   assign sum    = {1'b0, Out} + {1'b0, A};

   assign Count  = cnt;
   assign Full   = full;
   assign Recall = empty ? '0 : mem[rd_idx];

   // M+ on a non-empty bank rewrites the newest slot in place
   always_comb begin
      we    = 1'b0;
      waddr = wr_ptr;
      wdata = A;
      if (!reset) begin
         if (Sel == OP_STORE) begin
            we = 1'b1;
         end else if (Sel == OP_ACCUM) begin
            we    = 1'b1;
            wdata = sum[WIDTH-1:0];
            if (!empty) waddr = last;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_off  <= '0;
         cnt     <= '0;
         Out     <= '0;
         Carry   <= 1'b0;
         Dropped <= 1'b0;
      end else begin
         Dropped <= 1'b0;
         case (Sel)
            OP_STORE: begin
               wr_ptr  <= wr_ptr + PW'(1);
               Out     <= A;
               rd_off  <= '0;
               Carry   <= 1'b0;
               Dropped <= full;
               if (!full) cnt <= cnt + CW'(1);
            end
            OP_CLEAR: begin
               wr_ptr <= '0;
               rd_off <= '0;
               cnt    <= '0;
               Out    <= '0;
               Carry  <= 1'b0;
            end
            OP_ACCUM: begin
               Out    <= sum[WIDTH-1:0];
               rd_off <= '0;
               if (empty) begin
                  wr_ptr <= wr_ptr + PW'(1);
                  cnt    <= CW'(1);
                  Carry  <= 1'b0;
               end else begin
                  Carry  <= sum[WIDTH];
               end
            end
            OP_BACK: begin
               if (CW'(rd_off) + CW'(1) < cnt) rd_off <= rd_off + PW'(1);
            end
            OP_FWD: begin
               if (rd_off != '0) rd_off <= rd_off - PW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_result_bank.sv
// Directed self-checking bench for result_bank at WIDTH=8, DEPTH=4.
module tb_result_bank;

   logic       clock;
   logic       reset;
   logic [7:0] A;
   logic [2:0] Sel;
   logic [7:0] Out;
   logic [7:0] Recall;
   logic [2:0] Count;
   logic       Full;
   logic       Dropped;
   logic       Carry;

   int errors = 0;
   int checks = 0;

   localparam logic [2:0] HOLD  = 3'b000;
   localparam logic [2:0] STORE = 3'b011;
   localparam logic [2:0] CLEAR = 3'b100;
   localparam logic [2:0] ACCUM = 3'b101;
   localparam logic [2:0] BACK  = 3'b110;
   localparam logic [2:0] FWD   = 3'b111;

   result_bank #(.WIDTH(8), .DEPTH(4)) dut (
      .clock(clock), .reset(reset), .A(A), .Sel(Sel),
      .Out(Out), .Recall(Recall), .Count(Count),
      .Full(Full), .Dropped(Dropped), .Carry(Carry)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step(input logic [2:0] s, input logic [7:0] a);
      Sel = s;
      A   = a;
      @(posedge clock);
      #1;
      Sel = HOLD;
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      Sel   = STORE;
      A     = 8'h55;
      repeat (cycles) @(posedge clock);
      #1;
      reset = 1'b0;
      Sel   = HOLD;
   endtask

   task automatic test_reset();
      do_reset(2);
      checks++; if (Out !== 8'h00) begin errors++; $display("FAIL reset_out got=%h exp=00", Out); end
      checks++; if (Count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", Count); end
      checks++; if (Recall !== 8'h00) begin errors++; $display("FAIL reset_recall got=%h exp=00", Recall); end
      checks++; if (Full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", Full); end
      checks++; if (Dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped got=%b exp=0", Dropped); end
      checks++; if (Carry !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b exp=0", Carry); end
   endtask

   task automatic test_browse();
      do_reset(1);
      step(STORE, 8'h11);
      step(STORE, 8'h22);
      step(STORE, 8'h33);
      checks++; if (Out !== 8'h33) begin errors++; $display("FAIL browse_out got=%h exp=33", Out); end
      checks++; if (Count !== 3'd3) begin errors++; $display("FAIL browse_count got=%0d exp=3", Count); end
      checks++; if (Recall !== 8'h33) begin errors++; $display("FAIL browse_rc0 got=%h exp=33", Recall); end
      checks++; if (Full !== 1'b0) begin errors++; $display("FAIL browse_full got=%b exp=0", Full); end
      step(BACK, 8'h00);
      checks++; if (Recall !== 8'h22) begin errors++; $display("FAIL browse_back1 got=%h exp=22", Recall); end
      step(BACK, 8'h00);
      checks++; if (Recall !== 8'h11) begin errors++; $display("FAIL browse_back2 got=%h exp=11", Recall); end
      step(BACK, 8'h00);
      checks++; if (Recall !== 8'h11) begin errors++; $display("FAIL browse_back_sat got=%h exp=11", Recall); end
      step(FWD, 8'h00);
      checks++; if (Recall !== 8'h22) begin errors++; $display("FAIL browse_fwd got=%h exp=22", Recall); end
      step(STORE, 8'h44);
      checks++; if (Recall !== 8'h44) begin errors++; $display("FAIL browse_store got=%h exp=44", Recall); end
      checks++; if (Full !== 1'b1) begin errors++; $display("FAIL browse_full4 got=%b exp=1", Full); end
      step(BACK, 8'h00);
      checks++; if (Recall !== 8'h33) begin errors++; $display("FAIL browse_off0 got=%h exp=33", Recall); end
      step(FWD, 8'h00);
      step(FWD, 8'h00);
      checks++; if (Recall !== 8'h44) begin errors++; $display("FAIL browse_fwd_sat got=%h exp=44", Recall); end
   endtask

   task automatic test_wrap();
      do_reset(1);
      step(STORE, 8'h01);
      step(STORE, 8'h02);
      step(STORE, 8'h03);
      checks++; if (Full !== 1'b0) begin errors++; $display("FAIL wrap_full3 got=%b exp=0", Full); end
      step(STORE, 8'h04);
      checks++; if (Count !== 3'd4) begin errors++; $display("FAIL wrap_count4 got=%0d exp=4", Count); end
      checks++; if (Full !== 1'b1) begin errors++; $display("FAIL wrap_full4 got=%b exp=1", Full); end
      checks++; if (Dropped !== 1'b0) begin errors++; $display("FAIL wrap_drop4 got=%b exp=0", Dropped); end
      step(STORE, 8'h05);
      checks++; if (Dropped !== 1'b1) begin errors++; $display("FAIL wrap_drop5 got=%b exp=1", Dropped); end
      checks++; if (Count !== 3'd4) begin errors++; $display("FAIL wrap_count5 got=%0d exp=4", Count); end
      checks++; if (Recall !== 8'h05) begin errors++; $display("FAIL wrap_rc0 got=%h exp=05", Recall); end
      step(BACK, 8'h00);
      checks++; if (Dropped !== 1'b0) begin errors++; $display("FAIL wrap_drop_clr got=%b exp=0", Dropped); end
      checks++; if (Recall !== 8'h04) begin errors++; $display("FAIL wrap_rc1 got=%h exp=04", Recall); end
      step(BACK, 8'h00);
      checks++; if (Recall !== 8'h03) begin errors++; $display("FAIL wrap_rc2 got=%h exp=03", Recall); end
      step(BACK, 8'h00);
      checks++; if (Recall !== 8'h02) begin errors++; $display("FAIL wrap_rc3 got=%h exp=02", Recall); end
      step(BACK, 8'h00);
      checks++; if (Recall !== 8'h02) begin errors++; $display("FAIL wrap_rc_sat got=%h exp=02", Recall); end
   endtask

   task automatic test_back_to_back();
      step(STORE, 8'h06);
      checks++; if (Dropped !== 1'b1) begin errors++; $display("FAIL b2b_drop1 got=%b exp=1", Dropped); end
      step(STORE, 8'h07);
      checks++; if (Dropped !== 1'b1) begin errors++; $display("FAIL b2b_drop2 got=%b exp=1", Dropped); end
      checks++; if (Recall !== 8'h07) begin errors++; $display("FAIL b2b_recall got=%h exp=07", Recall); end
      step(HOLD, 8'h99);
      checks++; if (Dropped !== 1'b0) begin errors++; $display("FAIL b2b_drop_end got=%b exp=0", Dropped); end
      checks++; if (Out !== 8'h07) begin errors++; $display("FAIL b2b_hold_out got=%h exp=07", Out); end
   endtask

   task automatic test_clear();
      step(BACK, 8'h00);
      step(BACK, 8'h00);
      checks++; if (Recall !== 8'h05) begin errors++; $display("FAIL clear_pre got=%h exp=05", Recall); end
      step(CLEAR, 8'hAA);
      checks++; if (Out !== 8'h00) begin errors++; $display("FAIL clear_out got=%h exp=00", Out); end
      checks++; if (Count !== 3'd0) begin errors++; $display("FAIL clear_count got=%0d exp=0", Count); end
      checks++; if (Recall !== 8'h00) begin errors++; $display("FAIL clear_recall got=%h exp=00", Recall); end
      checks++; if (Full !== 1'b0) begin errors++; $display("FAIL clear_full got=%b exp=0", Full); end
      step(BACK, 8'h00);
      checks++; if (Recall !== 8'h00) begin errors++; $display("FAIL clear_back got=%h exp=00", Recall); end
      checks++; if (Count !== 3'd0) begin errors++; $display("FAIL clear_back_cnt got=%0d exp=0", Count); end
      do_reset(1);
      checks++; if (Count !== 3'd0) begin errors++; $display("FAIL clear_rst_cnt got=%0d exp=0", Count); end
      checks++; if (Out !== 8'h00) begin errors++; $display("FAIL clear_rst_out got=%h exp=00", Out); end
      step(STORE, 8'h09);
      checks++; if (Recall !== 8'h09) begin errors++; $display("FAIL clear_post got=%h exp=09", Recall); end
      checks++; if (Count !== 3'd1) begin errors++; $display("FAIL clear_post_cnt got=%0d exp=1", Count); end
   endtask

   task automatic test_accum();
      do_reset(1);
      step(STORE, 8'hF0);
      step(ACCUM, 8'h20);
      checks++; if (Out !== 8'h10) begin errors++; $display("FAIL acc_out got=%h exp=10", Out); end
      checks++; if (Carry !== 1'b1) begin errors++; $display("FAIL acc_carry got=%b exp=1", Carry); end
      checks++; if (Recall !== 8'h10) begin errors++; $display("FAIL acc_recall got=%h exp=10", Recall); end
      checks++; if (Count !== 3'd1) begin errors++; $display("FAIL acc_count got=%0d exp=1", Count); end
      step(3'b001, 8'h77);
      checks++; if (Carry !== 1'b1) begin errors++; $display("FAIL acc_hold_carry got=%b exp=1", Carry); end
      step(ACCUM, 8'h01);
      checks++; if (Out !== 8'h11) begin errors++; $display("FAIL acc2_out got=%h exp=11", Out); end
      checks++; if (Carry !== 1'b0) begin errors++; $display("FAIL acc2_carry got=%b exp=0", Carry); end
      checks++; if (Recall !== 8'h11) begin errors++; $display("FAIL acc2_recall got=%h exp=11", Recall); end
      step(STORE, 8'h30);
      step(ACCUM, 8'h05);
      step(BACK, 8'h00);
      checks++; if (Recall !== 8'h11) begin errors++; $display("FAIL acc3_older got=%h exp=11", Recall); end
      step(FWD, 8'h00);
      checks++; if (Recall !== 8'h35) begin errors++; $display("FAIL acc3_newest got=%h exp=35", Recall); end
      checks++; if (Count !== 3'd2) begin errors++; $display("FAIL acc3_count got=%0d exp=2", Count); end
   endtask

   task automatic test_accum_empty();
      do_reset(1);
      step(ACCUM, 8'h07);
      checks++; if (Out !== 8'h07) begin errors++; $display("FAIL acce_out got=%h exp=07", Out); end
      checks++; if (Count !== 3'd1) begin errors++; $display("FAIL acce_count got=%0d exp=1", Count); end
      checks++; if (Recall !== 8'h07) begin errors++; $display("FAIL acce_recall got=%h exp=07", Recall); end
      checks++; if (Carry !== 1'b0) begin errors++; $display("FAIL acce_carry got=%b exp=0", Carry); end
      step(STORE, 8'h08);
      step(BACK, 8'h00);
      checks++; if (Recall !== 8'h07) begin errors++; $display("FAIL acce_slot got=%h exp=07", Recall); end
   endtask

   initial begin
      reset = 1'b1;
      Sel   = HOLD;
      A     = 8'h00;
      test_reset();
      test_browse();
      test_wrap();
      test_back_to_back();
      test_clear();
      test_accum();
      test_accum_empty();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/result_bank.md
# result_bank

Parametrised successor to the calculator's single-register result holder. Holds a circular history of the last DEPTH results with store, clear, accumulate (M+) and recall-navigation operations decoded from the existing 3-bit `Sel` op bus. Sits after the ALU output mux. Drives the display path (`Out`) and a history-browse path (`Recall`).

## Interface
Parameters:
- WIDTH, 8, data width of results and storage slots
- DEPTH, 4, number of history slots; power of two, at least 2

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- A  in  WIDTH  result from ALU
- Sel  in  3  operation code, sampled every rising edge
- Out  out  WIDTH  registered current result
- Recall  out  WIDTH  history slot selected by recall offset; 0 when empty
- Count  out  $clog2(DEPTH+1)  number of valid slots, 0..DEPTH
- Full  out  1  Count == DEPTH
- Dropped  out  1  one-cycle pulse: a STORE overwrote the oldest slot
- Carry  out  1  carry-out of the most recent ACCUM

## Operation
Internal state:
- mem[DEPTH]
- wr_ptr, log2(DEPTH) bits, next write slot
- count
- rd_off, recall offset from newest, 0..count-1

Sel decode, evaluated only when reset=0:
- 3'b000/001/010 HOLD: no state change; Dropped <= 0.
- 3'b011 STORE:
  - mem[wr_ptr] <= A; wr_ptr <= wr_ptr+1 (wraps mod DEPTH); Out <= A; rd_off <= 0; Carry <= 0.
  - count <= min(count+1, DEPTH).
  - Dropped <= 1 iff count==DEPTH before the edge; else 0.
- 3'b100 CLEAR: count, wr_ptr, rd_off, Out, Carry, Dropped <= 0. mem contents are don't-care and must never be visible.
- 3'b101 ACCUM:
  - sum = Out + A, computed at WIDTH+1 bits. Out <= sum[WIDTH-1:0]; Carry <= sum[WIDTH]; rd_off <= 0; Dropped <= 0.
  - count>0: mem[wr_ptr-1] <= sum[WIDTH-1:0]; count and wr_ptr unchanged.
  - count==0: behaves as STORE of sum, which equals A. Slot wr_ptr is written, wr_ptr increments, count becomes 1, Carry <= 0.
- 3'b110 RECALL_BACK: rd_off <= rd_off+1 if rd_off < count-1, else unchanged (saturates at oldest). No change when count==0. Dropped <= 0.
- 3'b111 RECALL_FWD: rd_off <= rd_off-1 if rd_off>0, else unchanged (saturates at newest). Dropped <= 0.

Recall output:
- Combinational from registered state: mem[(wr_ptr-1-rd_off) mod DEPTH] when count>0, else 0.
- Pointer arithmetic wraps modulo DEPTH.

Invariant: count==0 implies Out==0.

Reset:
- Out, Recall, Count, Full, Dropped, Carry all 0; wr_ptr, rd_off 0.
- Reset has priority over any Sel value in the same cycle.

## Timing
- Every operation has 1-cycle latency. Out, Count, Full, Carry and Dropped change at the rising edge that samples Sel. Recall reflects the new state in the same cycle after that edge.
- No handshake: Sel is a level op code, executed once per cycle it is present. Sel held at STORE for N cycles performs N stores.
- Full is combinational from count. It is never asserted simultaneously with count<DEPTH.
- Dropped is high for exactly one cycle per overwriting STORE. Back-to-back overwriting STOREs keep it high continuously.
- Reset asserted mid-sequence (for example while browsing with rd_off>0) clears all state at that edge. The next cycle behaves as post-reset.

## Test plan
All scenarios use WIDTH=8, DEPTH=4.
- Reset: hold reset 2 cycles with Sel=011, A=0x55 -> Out=0, Count=0, Recall=0, Full=0, Dropped=0, Carry=0.
- History browse:
  - STORE 0x11, 0x22, 0x33 -> Out=0x33, Count=3, Recall=0x33.
  - RECALL_BACK x3 -> Recall 0x22, 0x11, 0x11 (saturated).
  - RECALL_FWD -> Recall 0x22.
  - STORE 0x44 -> Recall=0x44, rd_off 0.
- Wrap and overwrite:
  - STORE 0x01..0x05 -> Count=4, Full=1 after the fourth store.
  - Dropped=1 only in the cycle after the fifth store.
  - RECALL_BACK x3 -> Recall 0x05, 0x04, 0x03, 0x02.
- Accumulate:
  - STORE 0xF0, ACCUM A=0x20 -> Out=0x10, Carry=1, Recall=0x10, Count=1.
  - ACCUM A=0x01 -> Out=0x11, Carry=0.
- Accumulate on empty: after reset, ACCUM A=0x07 -> Out=0x07, Count=1, Recall=0x07, Carry=0.
- Clear and precedence:
  - CLEAR while rd_off=2, Count=4 -> Out=0, Count=0, Recall=0, Full=0.
  - Then RECALL_BACK -> no change.
  - Then reset=1 with Sel=011 -> Count stays 0.
